fetch_unit: RTL and testbench

Front-end fetch stage that generates sequential PCs, issues one instruction-cache request at a time, and pushes `{pc, instr}` entries into the instruction FIFO through a valid/ready enqueue port. It sits directly upstream of the instruction FIFO, driving that FIFO's `enq_valid`/`enq_data` and consuming its `enq_ready`. Branch/exception redirects re-steer the PC and squash any in-flight fetch. An `init` preload port lets benches start from an arbitrary PC, in the same way the FIFO can be preloaded.

---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control (init/redirect), cache request/response, FIFO enqueue.
// The fetch unit takes the master modport; the cache/FIFO side takes the slave modport.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                              init;
  logic [ADDR_WIDTH-1:0]             init_pc;
  logic                              redirect_valid;
  logic [ADDR_WIDTH-1:0]             redirect_pc;
  logic                              req_valid;
  logic                              req_ready;
  logic [ADDR_WIDTH-1:0]             req_addr;
  logic                              resp_valid;
  logic [INSTR_WIDTH-1:0]            resp_data;
  logic                              enq_valid;
  logic                              enq_ready;
  logic [ADDR_WIDTH+INSTR_WIDTH-1:0] enq_data;

  modport master (
    input  init, init_pc, redirect_valid, redirect_pc,
    input  req_ready, resp_valid, resp_data, enq_ready,
    output req_valid, req_addr, enq_valid, enq_data
  );

  modport slave (
    output init, init_pc, redirect_valid, redirect_pc,
    output req_ready, resp_valid, resp_data, enq_ready,
    input  req_valid, req_addr, enq_valid, enq_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Sequential-PC fetch stage: one outstanding cache request at a time, pushes {pc, instr}
// into the instruction FIFO; redirects re-steer the PC and squash any in-flight fetch.
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input logic          clk,
  input logic          rst_aL,
  fetch_unit_if.master bus
);
  localparam int ENTRY_WIDTH = ADDR_WIDTH + INSTR_WIDTH;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [ADDR_WIDTH-1:0]  w_pcNext;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [INSTR_WIDTH-1:0] w_instrNext;
  logic                   w_reqFire;
  logic                   w_enqValid;
  logic [ENTRY_WIDTH-1:0] w_enqData;
  logic                   w_unused;

  // Targets are word-aligned, so the low two address bits are simply dropped.
  assign w_unused = ^{bus.init_pc[1:0], bus.redirect_pc[1:0]};

  assign w_reqFire  = (r_state == REQ) && bus.req_ready;
  assign w_enqValid = (r_state == HOLD) && !bus.redirect_valid;
  assign w_enqData  = {r_pc, r_instr};

  assign bus.req_valid = (r_state == REQ);
  assign bus.req_addr  = r_pc;
  assign bus.enq_valid = w_enqValid;
  assign bus.enq_data  = w_enqData;

  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_instrNext = r_instr;
    if (bus.init) begin
      w_pcNext    = {bus.init_pc[ADDR_WIDTH-1:2], 2'b00};
      w_instrNext = '0;
      w_stateNext = REQ;
    end else if (bus.redirect_valid) begin
      // A request already accepted by the cache must have its response drained.
      w_pcNext = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      case (r_state)
        IDLE, HOLD: w_stateNext = REQ;
        REQ:        w_stateNext = w_reqFire ? DRAIN : REQ;
        WAIT:       w_stateNext = bus.resp_valid ? REQ : DRAIN;
        DRAIN:      w_stateNext = bus.resp_valid ? REQ : DRAIN;
        default:    w_stateNext = REQ;
      endcase
    end else begin
      case (r_state)
        IDLE: w_stateNext = REQ;
        REQ:  if (w_reqFire) w_stateNext = WAIT;
        WAIT: if (bus.resp_valid) begin
          w_instrNext = bus.resp_data;
          w_stateNext = HOLD;
        end
        HOLD: if (w_enqValid && bus.enq_ready) begin
          w_pcNext    = r_pc + ADDR_WIDTH'(4);
          w_stateNext = REQ;
        end
        DRAIN: if (bus.resp_valid) w_stateNext = REQ;
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
      r_instr <= w_instrNext;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cache responder and a scoreboard of expected
// {pc, instr} entries, compared against every FIFO enqueue handshake.
module tb_fetch_unit;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int EW = AW + IW;
  localparam logic [AW-1:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_aL;

  fetch_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(RESET_PC)) dut (
    .clk    (clk),
    .rst_aL (rst_aL),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int cycleNo = 0;
  int enqCount = 0;
  int respDue = 0;
  int respDelay = 1;
  logic [AW-1:0] modelPc;
  logic [AW-1:0] pendPc;
  logic pendLive = 1'b0;
  logic [IW-1:0] respData = 32'h0000_0013;
  logic [EW-1:0] expQ[$];
  int enqCycles[$];

  task automatic checkOutput(input string tag, input logic [EW-1:0] observed, input logic [EW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycleNo++;
  endtask

  // One clock of the environment: score the current cycle, then drive the cache response.
  task automatic applyStimulus();
    logic acc;
    logic enqFire;
    logic [EW-1:0] expEntry;
    #1;
    acc = bus.req_valid && bus.req_ready;
    enqFire = bus.enq_valid && bus.enq_ready;
    if (bus.resp_valid && pendLive && !bus.redirect_valid && !bus.init) begin
      expQ.push_back({pendPc, bus.resp_data});
      pendLive = 1'b0;
    end
    if (enqFire) begin
      checkOutput("enqExpected", EW'(enqFire), EW'(expQ.size() != 0));
      if (expQ.size() != 0) begin
        expEntry = expQ.pop_front();
        checkOutput("enqData", bus.enq_data, expEntry);
      end
      enqCount++;
      enqCycles.push_back(cycleNo);
      modelPc = modelPc + 32'd4;
    end
    if (bus.redirect_valid || bus.init) begin
      pendLive = 1'b0;
      expQ.delete();
      modelPc = bus.init ? {bus.init_pc[AW-1:2], 2'b00} : {bus.redirect_pc[AW-1:2], 2'b00};
    end
    if (acc) begin
      checkOutput("reqAddr", EW'(bus.req_addr), EW'(modelPc));
      pendPc = modelPc;
      pendLive = !(bus.redirect_valid || bus.init);
      respDue = respDelay;
    end
    tick();
    bus.resp_valid = 1'b0;
    if (respDue > 0) begin
      respDue--;
      if (respDue == 0) begin
        bus.resp_valid = 1'b1;
        bus.resp_data = respData;
      end
    end
  endtask

  task automatic runUntilEnq(input int target, input int budget);
    int n = 0;
    while (enqCount < target && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("enqCount", EW'(enqCount), EW'(target));
  endtask

  task automatic runUntilHold(input int budget);
    int n = 0;
    while (bus.enq_valid !== 1'b1 && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("reachHold", EW'(bus.enq_valid), EW'(1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_aL = 1'b0;
    bus.init = 1'b0;
    bus.init_pc = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.req_ready = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_data = '0;
    bus.enq_ready = 1'b0;
    modelPc = RESET_PC;
    #1;
    checkOutput("rstReqValid", EW'(bus.req_valid), EW'(0));
    checkOutput("rstEnqValid", EW'(bus.enq_valid), EW'(0));
    checkOutput("rstReqAddr", EW'(bus.req_addr), EW'(RESET_PC));
    checkOutput("rstEnqData", bus.enq_data, {RESET_PC, 32'h0});
    tick();
    tick();
    rst_aL = 1'b1;
    $display("[TB] reset released, free-run");
    checkOutput("idleReqValid", EW'(bus.req_valid), EW'(0));
    bus.req_ready = 1'b1;
    bus.enq_ready = 1'b1;
    applyStimulus();
    checkOutput("firstReqValid", EW'(bus.req_valid), EW'(1));
    checkOutput("firstReqAddr", EW'(bus.req_addr), EW'(RESET_PC));
    runUntilEnq(3, 20);
    if (enqCycles.size() == 3) begin
      checkOutput("spacing01", EW'(enqCycles[1] - enqCycles[0]), EW'(3));
      checkOutput("spacing12", EW'(enqCycles[2] - enqCycles[1]), EW'(3));
    end else begin
      checkOutput("spacingCount", EW'(enqCycles.size()), EW'(3));
    end

    $display("[TB] FIFO backpressure");
    bus.enq_ready = 1'b0;
    runUntilHold(10);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bpEnqValid", EW'(bus.enq_valid), EW'(1));
      checkOutput("bpEnqData", bus.enq_data, {modelPc, 32'h0000_0013});
      checkOutput("bpReqValid", EW'(bus.req_valid), EW'(0));
      checkOutput("bpReqAddr", EW'(bus.req_addr), EW'(modelPc));
      applyStimulus();
    end
    bus.enq_ready = 1'b1;
    runUntilEnq(4, 1);

    $display("[TB] redirect in WAIT");
    respDelay = 2;
    respData = 32'h0000_0093;
    checkOutput("rdReqValid", EW'(bus.req_valid), EW'(1));
    applyStimulus();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_1003;
    applyStimulus();
    bus.redirect_valid = 1'b0;
    checkOutput("drainReqValid", EW'(bus.req_valid), EW'(0));
    checkOutput("drainEnqValid", EW'(bus.enq_valid), EW'(0));
    checkOutput("drainRespDriven", EW'(bus.resp_valid), EW'(1));
    applyStimulus();
    checkOutput("postDrainReqValid", EW'(bus.req_valid), EW'(1));
    checkOutput("postDrainReqAddr", EW'(bus.req_addr), EW'(32'h0000_1000));
    respDelay = 1;
    runUntilEnq(5, 10);

    $display("[TB] redirect in HOLD");
    runUntilHold(10);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_2002;
    #1;
    checkOutput("holdRdEnqValid", EW'(bus.enq_valid), EW'(0));
    applyStimulus();
    bus.redirect_valid = 1'b0;
    checkOutput("holdRdReqValid", EW'(bus.req_valid), EW'(1));
    checkOutput("holdRdReqAddr", EW'(bus.req_addr), EW'(32'h0000_2000));
    checkOutput("holdRdNoEnq", EW'(enqCount), EW'(5));

    $display("[TB] init preload and PC wrap");
    bus.req_ready = 1'b0;
    bus.init = 1'b1;
    bus.init_pc = 32'hDEAD_BEE4;
    applyStimulus();
    bus.init = 1'b0;
    checkOutput("initReqValid", EW'(bus.req_valid), EW'(1));
    checkOutput("initReqAddr", EW'(bus.req_addr), EW'(32'hDEAD_BEE4));
    checkOutput("initEnqData", bus.enq_data, {32'hDEAD_BEE4, 32'h0});
    bus.init = 1'b1;
    bus.init_pc = 32'hFFFF_FFFC;
    applyStimulus();
    bus.init = 1'b0;
    bus.req_ready = 1'b1;
    runUntilEnq(6, 10);
    checkOutput("wrapReqValid", EW'(bus.req_valid), EW'(1));
    checkOutput("wrapReqAddr", EW'(bus.req_addr), EW'(32'h0000_0000));

    $display("[TB] reset during WAIT");
    respDelay = 2;
    respData = 32'h0000_0033;
    applyStimulus();
    rst_aL = 1'b0;
    #1;
    checkOutput("midRstReqValid", EW'(bus.req_valid), EW'(0));
    checkOutput("midRstEnqValid", EW'(bus.enq_valid), EW'(0));
    checkOutput("midRstReqAddr", EW'(bus.req_addr), EW'(RESET_PC));
    respDue = 0;
    pendLive = 1'b0;
    expQ.delete();
    modelPc = RESET_PC;
    tick();
    rst_aL = 1'b1;
    bus.resp_valid = 1'b1;
    bus.resp_data = 32'hBAD0_BAD0;
    checkOutput("staleIdleReqValid", EW'(bus.req_valid), EW'(0));
    applyStimulus();
    bus.req_ready = 1'b0;
    bus.resp_valid = 1'b1;
    bus.resp_data = 32'hBAD1_BAD1;
    #1;
    checkOutput("staleReqValid", EW'(bus.req_valid), EW'(1));
    checkOutput("staleReqAddr", EW'(bus.req_addr), EW'(RESET_PC));
    checkOutput("staleEnqValid", EW'(bus.enq_valid), EW'(0));
    applyStimulus();
    bus.req_ready = 1'b1;
    respDelay = 1;
    runUntilEnq(7, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
